// File: rtl/ddr_port_arbiter.sv
// Two-port front end for the DDR3 controller user interface.
// Round-robin grant, one command per grant, registered command issue,
// in-order read tag FIFO for return routing, outstanding-write counter and idle flag.
module ddr_port_arbiter #(
    parameter int unsigned TAG_DEPTH_LOG2 = 3,
    parameter int unsigned WR_CNT_W       = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    // requester port 0 (CPU/cache)
    input  logic         p0_valid,
    input  logic         p0_write,
    input  logic [31:0]  p0_addr,
    input  logic [127:0] p0_wdata,
    output logic         p0_ready,
    output logic         p0_rvalid,
    output logic [127:0] p0_rdata,
    // requester port 1 (DMA/video)
    input  logic         p1_valid,
    input  logic         p1_write,
    input  logic [31:0]  p1_addr,
    input  logic [127:0] p1_wdata,
    output logic         p1_ready,
    output logic         p1_rvalid,
    output logic [127:0] p1_rdata,
    // controller read side
    output logic         rd_addr_en,
    output logic [31:0]  rd_addr,
    output logic         rd_en,
    input  logic         rd_valid,
    input  logic [127:0] rd_data,
    input  logic         rd_busy,
    // controller write side
    input  logic         wr_busy,
    output logic         wr_en,
    output logic         wr_addr_en,
    output logic [31:0]  wr_addr,
    output logic [127:0] wr_data,
    output logic [15:0]  wr_datamask,
    input  logic         wr_ack,
    // status
    output logic         idle
);

    localparam int unsigned TAG_DEPTH = 1 << TAG_DEPTH_LOG2;
    localparam logic [TAG_DEPTH_LOG2:0] TAG_FULL = {1'b1, {TAG_DEPTH_LOG2{1'b0}}};

    // tag FIFO: one bit per entry holding the requesting port id
    logic [TAG_DEPTH-1:0]      r_tag_mem;
    logic [TAG_DEPTH_LOG2-1:0] r_tag_wp;
    logic [TAG_DEPTH_LOG2-1:0] r_tag_rp;
    logic [TAG_DEPTH_LOG2:0]   r_tag_cnt;

    logic [WR_CNT_W-1:0]       r_wr_cnt;
    logic                      r_last_p1;     // 1: port 1 granted last, port 0 favoured next
    logic                      r_rd_en;
    logic                      r_rd_en_q;     // rd_en as seen by the controller last cycle

    logic                      r_rd_addr_en;
    logic [31:0]               r_rd_addr;
    logic                      r_wr_en;
    logic [31:0]               r_wr_addr;
    logic [127:0]              r_wr_data;

    logic w_rd_ok, w_wr_ok;
    logic w_elig0, w_elig1;
    logic w_gnt0, w_gnt1, w_gnt_any, w_gnt_wr;
    logic [31:0]  w_gnt_addr;
    logic [127:0] w_gnt_wdata;
    logic w_push, w_pop, w_tag_head;
    logic w_winc, w_wdec;

    // Occupancy is updated at grant time, so a command granted in this cycle
    // already counts against the limits seen by the next grant.
    assign w_rd_ok = !rd_busy && (r_tag_cnt != TAG_FULL);
    assign w_wr_ok = !wr_busy && (r_wr_cnt != '1);

    // Eligibility, round-robin grant and winner mux
    always_comb begin
        w_elig0     = p0_valid && (p0_write ? w_wr_ok : w_rd_ok);
        w_elig1     = p1_valid && (p1_write ? w_wr_ok : w_rd_ok);
        w_gnt0      = reset_n && w_elig0 && (!w_elig1 || r_last_p1);
        w_gnt1      = reset_n && w_elig1 && (!w_elig0 || !r_last_p1);
        w_gnt_any   = w_gnt0 || w_gnt1;
        w_gnt_wr    = w_gnt1 ? p1_write : p0_write;
        w_gnt_addr  = w_gnt1 ? p1_addr  : p0_addr;
        w_gnt_wdata = w_gnt1 ? p1_wdata : p0_wdata;
        w_push      = w_gnt_any && !w_gnt_wr;
        w_winc      = w_gnt_any && w_gnt_wr;
        w_pop       = rd_valid && r_rd_en_q && (r_tag_cnt != '0);
        w_tag_head  = r_tag_mem[r_tag_rp];
        w_wdec      = wr_ack && (r_wr_cnt != '0);
    end

    assign p0_ready    = w_gnt0;
    assign p1_ready    = w_gnt1;
    assign p0_rvalid   = w_pop && !w_tag_head;
    assign p1_rvalid   = w_pop && w_tag_head;
    assign p0_rdata    = p0_rvalid ? rd_data : '0;
    assign p1_rdata    = p1_rvalid ? rd_data : '0;

    assign rd_addr_en  = r_rd_addr_en;
    assign rd_addr     = r_rd_addr;
    assign rd_en       = r_rd_en;
    assign wr_en       = r_wr_en;
    assign wr_addr_en  = r_wr_en;
    assign wr_addr     = r_wr_addr;
    assign wr_data     = r_wr_data;
    assign wr_datamask = '0;

    assign idle = reset_n && (r_tag_cnt == '0) && (r_wr_cnt == '0) && !r_rd_addr_en && !r_wr_en;

    // Read data consume enable: rises on the first clock after reset and stays high
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_en   <= 1'b0;
            r_rd_en_q <= 1'b0;
        end else begin
            r_rd_en   <= 1'b1;
            r_rd_en_q <= r_rd_en;
        end
    end

    // Round-robin pointer moves only on an actual grant
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_last_p1 <= 1'b1;
        end else if (w_gnt0) begin
            r_last_p1 <= 1'b0;
        end else if (w_gnt1) begin
            r_last_p1 <= 1'b1;
        end
    end

    // Command output register: one strobe the cycle after a grant
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_addr_en <= 1'b0;
            r_rd_addr    <= '0;
            r_wr_en      <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
        end else begin
            r_rd_addr_en <= w_push;
            r_wr_en      <= w_winc;
            if (w_push) begin
                r_rd_addr <= w_gnt_addr;
            end
            if (w_winc) begin
                r_wr_addr <= w_gnt_addr;
                r_wr_data <= w_gnt_wdata;
            end
        end
    end

    // Tag FIFO: push requester id on read grant, pop on each consumed beat
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tag_mem <= '0;
            r_tag_wp  <= '0;
            r_tag_rp  <= '0;
            r_tag_cnt <= '0;
        end else begin
            if (w_push) begin
                r_tag_mem[r_tag_wp] <= w_gnt1;
                r_tag_wp            <= r_tag_wp + 1'b1;
            end
            if (w_pop) begin
                r_tag_rp <= r_tag_rp + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_tag_cnt <= r_tag_cnt + 1'b1;
                2'b01:   r_tag_cnt <= r_tag_cnt - 1'b1;
                default: r_tag_cnt <= r_tag_cnt;
            endcase
        end
    end

    // Outstanding-write counter: +1 on write grant, -1 on wr_ack (never below zero)
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_cnt <= '0;
        end else begin
            case ({w_winc, w_wdec})
                2'b10:   r_wr_cnt <= r_wr_cnt + 1'b1;
                2'b01:   r_wr_cnt <= r_wr_cnt - 1'b1;
                default: r_wr_cnt <= r_wr_cnt;
            endcase
        end
    end

    // A returned beat with no read outstanding is a controller protocol error
    a_no_pop_when_empty: assert property (@(posedge clk) disable iff (!reset_n)
        !(rd_valid && r_rd_en_q && (r_tag_cnt == '0)));

endmodule
